sw_input: RTL and testbench

Switch-input peripheral for the attosoc FPGA build, and the input-direction counterpart of the SoC LED output path. It synchronises and debounces the board switches, detects rising and falling edges, and latches those edges into sticky pending registers. The SoC CPU reads and clears these registers over its native memory bus, and an optional interrupt line can be raised. It sits beside the LED output logic in the top level, with the switch pins as input and the SoC bus as consumer.

---
 rtl/sw_input_pkg.sv | 12 +
 rtl/sw_input_if.sv | 24 ++
 rtl/sw_debounce.sv | 59 +++++
 rtl/sw_input.sv | 134 +++++++++++++
 tb/tb_sw_input.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sw_input_pkg.sv
// sw_input_pkg: register offsets and bus width shared by the switch-input
// peripheral, its bus interface and its testbench.
package sw_input_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] REG_STATE    = 2'd0;
    localparam logic [1:0] REG_RISE     = 2'd1;
    localparam logic [1:0] REG_FALL     = 2'd2;
    localparam logic [1:0] REG_IRQ_MASK = 2'd3;

endpackage

// File: rtl/sw_input_if.sv
// sw_input_if: native SoC memory bus as seen by one peripheral.
// The CPU side uses the master modport, the peripheral the slave modport.
interface sw_input_if;
    import sw_input_pkg::*;

    logic              mem_valid;
    logic              mem_sel;
    logic [3:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: one switch bit. Two-flop synchroniser, a saturating
// stability counter and the debounced value. The rise/fall pulses are
// combinational and high in the cycle whose clock edge flips the stable
// value, so a pending register sampling them updates on the same edge.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic sw_raw,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; flip the stable value once the
    // count has run its full length, clear the count on any agreement.
    always_comb begin
        sync1_d  = sw_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter and stable value all clear asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable     = stable_q;
    assign rise_pulse = stable_d & ~stable_q;
    assign fall_pulse = ~stable_d & stable_q;

endmodule

// File: rtl/sw_input.sv
// sw_input: debounced board switches with sticky rise/fall pending
// registers readable and write-1-to-clear over the SoC memory bus.
// Define SW_INPUT_IRQ_EN to add the IRQ_MASK register and the irq output;
// without it irq is tied low and offset 3 reads as zero.
module sw_input
    import sw_input_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_SW-1:0] sw,
    sw_input_if.slave       bus,
    output logic            irq
);

    logic [N_SW-1:0]   stable, rise_pulse, fall_pulse;
    logic [N_SW-1:0]   rise_pend_q, rise_pend_d;
    logic [N_SW-1:0]   fall_pend_q, fall_pend_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              accept, wr_lane0;
    logic [1:0]        reg_sel;
    logic [N_SW-1:0]   wr_bits;
    logic [DATA_W-1:0] rd_val;
    logic              unused_bus;
`ifdef SW_INPUT_IRQ_EN
    logic [N_SW-1:0]   irq_mask_q, irq_mask_d;
    logic              irq_q, irq_d;
`endif

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .resetn     (resetn),
            .sw_raw     (sw[i]),
            .stable     (stable[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    // Bus decode: one access per two cycles, writes only touch byte lane 0.
    always_comb begin
        accept   = bus.mem_valid & bus.mem_sel & ~mem_ready_q;
        reg_sel  = bus.mem_addr[3:2];
        wr_lane0 = accept & bus.mem_wstrb[0];
        wr_bits  = bus.mem_wdata[N_SW-1:0];
    end

    // Pending bits: apply the W1C clear first so a same-cycle edge wins.
    always_comb begin
        rise_pend_d = rise_pend_q;
        fall_pend_d = fall_pend_q;
        if (wr_lane0 && reg_sel == REG_RISE) begin
            rise_pend_d = rise_pend_q & ~wr_bits;
        end
        if (wr_lane0 && reg_sel == REG_FALL) begin
            fall_pend_d = fall_pend_q & ~wr_bits;
        end
        rise_pend_d = rise_pend_d | rise_pulse;
        fall_pend_d = fall_pend_d | fall_pulse;
    end

    // Read mux, zero-extended; the response is held for the ready cycle only.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_STATE:    rd_val[N_SW-1:0] = stable;
            REG_RISE:     rd_val[N_SW-1:0] = rise_pend_q;
            REG_FALL:     rd_val[N_SW-1:0] = fall_pend_q;
            REG_IRQ_MASK: begin
`ifdef SW_INPUT_IRQ_EN
                rd_val[N_SW-1:0] = irq_mask_q;
`endif
            end
            default:      rd_val = '0;
        endcase
        mem_ready_d = accept;
        mem_rdata_d = accept ? rd_val : '0;
    end

    // Pending registers and bus response flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

`ifdef SW_INPUT_IRQ_EN
    // Mask register and the registered level interrupt.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_lane0 && reg_sel == REG_IRQ_MASK) begin
            irq_mask_d = wr_bits;
        end
        irq_d = |((rise_pend_q | fall_pend_q) & irq_mask_q);
    end

    // Mask and irq flops clear with the rest of the block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;

    // Bus bits the register map never looks at.
    assign unused_bus = &{1'b0, bus.mem_addr[1:0], bus.mem_wstrb[3:1],
                          bus.mem_wdata[DATA_W-1:N_SW]};

endmodule

// File: tb/tb_sw_input.sv
// tb_sw_input: directed checks of sw_input with DEBOUNCE_CYCLES=8.
// Inputs change on the falling clock edge and outputs are sampled there too.
module tb_sw_input;
    import sw_input_pkg::*;

    localparam int N_SW = 4;
    localparam int DC   = 8;
    localparam logic [3:0] A_STATE = 4'h0;
    localparam logic [3:0] A_RISE  = 4'h4;
    localparam logic [3:0] A_FALL  = 4'h8;
    localparam logic [3:0] A_MASK  = 4'hC;

    logic            clk    = 1'b0;
    logic            resetn = 1'b0;
    logic [N_SW-1:0] sw     = '0;
    logic            irq;
    int              n_checks = 0;
    int              n_fail   = 0;

    sw_input_if bus_if();

    sw_input #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw     (sw),
        .bus    (bus_if),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus access starting at a falling edge; returns after ready drops.
    task automatic bus_access(input logic [3:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic [31:0] rdata,
                              output logic rdy, output logic rdy_after,
                              output logic [31:0] rdata_after);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_sel   = 1'b1;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        bus_if.mem_wstrb = wstrb;
        @(negedge clk);
        rdy   = bus_if.mem_ready;
        rdata = bus_if.mem_rdata;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_sel   = 1'b0;
        bus_if.mem_wstrb = 4'h0;
        @(negedge clk);
        rdy_after   = bus_if.mem_ready;
        rdata_after = bus_if.mem_rdata;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
        logic r1, r2;
        logic [31:0] d2;
        bus_access(addr, 32'h0, 4'h0, data, r1, r2, d2);
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        logic r1, r2;
        logic [31:0] d1, d2;
        bus_access(addr, data, 4'hF, d1, r1, r2, d2);
    endtask

    task automatic test_reset;
        logic [31:0] rd, rd2;
        logic r1, r2;
        resetn = 1'b0;
        sw = '0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_sel   = 1'b0;
        bus_if.mem_addr  = 4'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_wstrb = 4'h0;
        wait_cycles(3);
        n_checks++; if (bus_if.mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", bus_if.mem_ready); end
        n_checks++; if (bus_if.mem_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus_if.mem_rdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        resetn = 1'b1;
        wait_cycles(2);
        bus_access(A_STATE, 32'h0, 4'h0, rd, r1, r2, rd2);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_state: got %h expected 0", rd); end
        n_checks++; if (r1 !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_pulse: got %b expected 1", r1); end
        n_checks++; if (r2 !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_drop: got %b expected 0", r2); end
        n_checks++; if (rd2 !== 32'h0) begin n_fail++; $display("[TB] FAIL rdata_idle: got %h expected 0", rd2); end
    endtask

    task automatic test_rise_debounce;
        logic [31:0] rd;
        sw[1] = 1'b1;
        wait_cycles(9);
        reg_read(A_STATE, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL state_before_flip: got %h expected 0", rd); end
        reg_read(A_STATE, rd);
        n_checks++; if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL state_after_flip: got %h expected 2", rd); end
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL rise_set: got %h expected 2", rd); end
        reg_read(A_FALL, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL fall_quiet: got %h expected 0", rd); end
        reg_write(A_RISE, 32'h2);
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL rise_w1c: got %h expected 0", rd); end
    endtask

    task automatic test_glitch;
        logic [31:0] rd;
        sw[0] = 1'b1;
        wait_cycles(5);
        sw[0] = 1'b0;
        wait_cycles(20);
        reg_read(A_STATE, rd);
        n_checks++; if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL glitch_state: got %h expected 2", rd); end
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL glitch_rise: got %h expected 0", rd); end
        reg_read(A_FALL, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL glitch_fall: got %h expected 0", rd); end
        reg_write(A_STATE, 32'hF);
        reg_read(A_STATE, rd);
        n_checks++; if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL state_ro: got %h expected 2", rd); end
    endtask

    task automatic test_set_wins;
        logic [31:0] rd;
        sw[0] = 1'b1;
        wait_cycles(12);
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL rise_sw0: got %h expected 1", rd); end
        reg_write(A_RISE, 32'h1);
        sw[0] = 1'b0;
        wait_cycles(9);
        reg_write(A_FALL, 32'h1);
        reg_read(A_FALL, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL set_wins: got %h expected 1", rd); end
        reg_read(A_STATE, rd);
        n_checks++; if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL state_sw0_low: got %h expected 2", rd); end
        reg_write(A_FALL, 32'h1);
        reg_read(A_FALL, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL fall_w1c: got %h expected 0", rd); end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
`ifdef SW_INPUT_IRQ_EN
        reg_write(A_MASK, 32'h4);
        reg_read(A_MASK, rd);
        n_checks++; if (rd !== 32'h4) begin n_fail++; $display("[TB] FAIL mask_rw: got %h expected 4", rd); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
        sw[2] = 1'b1;
        wait_cycles(10);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_at_flip: got %b expected 0", irq); end
        wait_cycles(1);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_after_flip: got %b expected 1", irq); end
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h4) begin n_fail++; $display("[TB] FAIL rise_sw2: got %h expected 4", rd); end
        reg_write(A_RISE, 32'h4);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_cleared: got %b expected 0", irq); end
        sw[3] = 1'b1;
        wait_cycles(12);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_masked: got %b expected 0", irq); end
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h8) begin n_fail++; $display("[TB] FAIL rise_sw3: got %h expected 8", rd); end
`else
        reg_write(A_MASK, 32'hF);
        reg_read(A_MASK, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL mask_absent: got %h expected 0", rd); end
        sw[2] = 1'b1;
        wait_cycles(12);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_tied: got %b expected 0", irq); end
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h4) begin n_fail++; $display("[TB] FAIL rise_sw2: got %h expected 4", rd); end
        sw[3] = 1'b1;
        wait_cycles(12);
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'hC) begin n_fail++; $display("[TB] FAIL rise_sw3: got %h expected c", rd); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        sw = 4'h0;
        wait_cycles(12);
        sw = 4'hF;
        wait_cycles(12);
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'hF) begin n_fail++; $display("[TB] FAIL rise_all: got %h expected f", rd); end
`ifdef SW_INPUT_IRQ_EN
        reg_write(A_MASK, 32'hF);
        wait_cycles(1);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_before_reset: got %b expected 1", irq); end
`endif
        sw[0] = 1'b0;
        wait_cycles(5);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_sel   = 1'b1;
        bus_if.mem_addr  = A_RISE;
        bus_if.mem_wstrb = 4'h0;
        @(posedge clk);
        #2;
        n_checks++; if (bus_if.mem_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_before_reset: got %b expected 1", bus_if.mem_ready); end
        resetn = 1'b0;
        #1;
        n_checks++; if (bus_if.mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL async_ready: got %b expected 0", bus_if.mem_ready); end
        n_checks++; if (bus_if.mem_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL async_rdata: got %h expected 0", bus_if.mem_rdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL async_irq: got %b expected 0", irq); end
        bus_if.mem_valid = 1'b0;
        bus_if.mem_sel   = 1'b0;
        sw = 4'hF;
        @(negedge clk);
        resetn = 1'b1;
        wait_cycles(9);
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL pend_cleared: got %h expected 0", rd); end
        reg_read(A_RISE, rd);
        n_checks++; if (rd !== 32'hF) begin n_fail++; $display("[TB] FAIL rise_after_reset: got %h expected f", rd); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_after_reset: got %b expected 0", irq); end
        reg_read(A_MASK, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL mask_after_reset: got %h expected 0", rd); end
    endtask

    initial begin
        $display("[TB] sw_input directed test, DEBOUNCE_CYCLES=%0d", DC);
        test_reset();
        test_rise_debounce();
        test_glitch();
        test_set_wins();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
